gametank_blitter: RTL and testbench
===================================

Name: gametank_blitter

Overview:
- Sprite/rectangle copy engine behind the PPU chip-enable window, driven by CPU register writes at offsets 0-7.
- Copies a W×H rectangle from graphics RAM (GRAM) into the 128×128 8-bit framebuffer (VRAM) at one pixel per clock. Colour-fill is an alternative to copying.
- Drives the blitter IRQ into the CPU interrupt combiner and a busy flag that the top level may use for pause_cpu.

Parameters:
- FB_BITS, 7, log2 of framebuffer edge in pixels (128); all coordinate arithmetic wraps modulo 2^FB_BITS.

Ports:
- i_clk_cpu  in  1  CPU clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  register window select from the bus control unit.
- i_rnw  in  1  1=read, 0=write; only writes have effect.
- i_addr  in  3  register offset: 0 VX, 1 VY, 2 GX, 3 GY, 4 WIDTH, 5 HEIGHT, 6 START, 7 COLOR.
- i_data  in  8  CPU write data.
- i_dma_enable  in  1  blitter enable from the DMA flags register.
- i_colorfill  in  1  1=write COLOR instead of GRAM data.
- i_opaque  in  1  0=GRAM pixel value 0x00 is transparent (not written).
- i_irq_en  in  1  IRQ enable.
- i_gram_bank  in  2  GRAM bank; forms o_gram_addr[15:14].
- i_irq_ack  in  1  clears o_irq.
- o_gram_addr  out  16  GRAM read address {bank, srcY[6:0], srcX[6:0]}.
- o_gram_re  out  1  GRAM read strobe; data returns on i_gram_data exactly 1 cycle later.
- i_gram_data  in  8  GRAM read data.
- o_vram_addr  out  14  VRAM write address {dstY[6:0], dstX[6:0]}.
- o_vram_we  out  1  VRAM write strobe.
- o_vram_data  out  8  VRAM write data.
- o_busy  out  1  blit in progress.
- o_irq  out  1  completion interrupt, level.

Behaviour:
- Reset: all registers, counters, pipeline state and outputs go to 0; state goes to IDLE; o_irq goes to 0. Reset mid-blit aborts the blit and no further VRAM writes occur from the next cycle.
- Register write: i_ce & ~i_rnw loads the register at i_addr in 1 cycle. WIDTH[7] is flipX and HEIGHT[7] is flipY; their [6:0] fields are W and H. Writes while busy update the registers but not the active blit.
- Start condition: write to offset 6 with i_data[0]=1, i_dma_enable=1 and state IDLE. START writes while busy, or with i_dma_enable=0, are ignored.
- On start, all parameters are latched into working copies.
- State machine:
  - IDLE -> RUN on start. If W=0 or H=0, IDLE -> DONE instead.
  - RUN: 1 pixel per cycle. Column c counts 0..W-1 and wraps to 0, then row r increments, r counting 0..H-1. After the last pixel, RUN -> DRAIN.
  - DRAIN: 1 cycle to retire the final pipelined write, then -> DONE.
  - DONE: 1 cycle, then -> IDLE; sets o_irq if i_irq_en=1.
- Addressing:
  - srcX = GX + (flipX ? W-1-c : c) mod 128.
  - srcY = GY + (flipY ? H-1-r : r) mod 128.
  - dstX = VX + c mod 128.
  - dstY = VY + r mod 128.
  - Coordinate overflow wraps and never carries into the bank or row fields.
- Pipeline:
  - The GRAM read for pixel k is issued in RUN cycle k.
  - The VRAM write for pixel k occurs in cycle k+1, with o_vram_addr held for that pixel.
  - o_vram_we = valid & (i_colorfill | i_opaque | i_gram_data != 0).
  - In colour-fill mode o_gram_re=0, o_vram_data=COLOR, and fill is always opaque.
- Timing:
  - o_busy=1 from the cycle after the START write through DRAIN: W*H+1 cycles.
  - o_irq rises on the cycle after DRAIN.
  - Zero-size blit: busy for 0 cycles and o_irq rises 1 cycle after the START write.
- IRQ:
  - o_irq stays set until i_irq_ack=1, or a write to START with i_data[0]=0.
  - If set and clear occur in the same cycle, set wins.
  - i_irq_en=0 at DONE means no IRQ is raised.
- Simultaneous events: i_reset overrides everything. A START write in the DONE cycle is ignored (state is not IDLE).

Test Plan:
- Copy: VX=10,VY=20,GX=0,GY=0,W=4,H=2, GRAM[n]=n+1, START=1 -> 8 writes to VRAM 0x0A0A..0x0A0D, 0x0A8A..0x0A8D with data 1..4, 129..132; o_busy for exactly 9 cycles; o_irq=1 the cycle after.
- Transparency/flip: W=4,H=1, flipX, GRAM row {0,5,6,7}, i_opaque=0 -> writes data 7,6,5 at dstX 0..2, no write at dstX 3; with i_opaque=1 -> 4 writes.
- Wrap: VX=126,VY=127,W=4,H=2, colour fill, COLOR=0x3C -> dst addresses (127,126),(127,127),(127,0),(127,1),(0,126),(0,127),(0,0),(0,1), all data 0x3C, o_gram_re never asserted.
- Ignored start: START during busy, and START with i_dma_enable=0 -> no restart, write count unchanged; VX written mid-blit does not alter the current destinations.
- Reset mid-blit: assert i_reset at pixel 3 of a 16-pixel blit -> o_vram_we=0 from the next cycle; o_busy=0 and o_irq=0; a new START then runs normally.
- IRQ control: W=0 START with i_irq_en=1 -> o_irq after 1 cycle; i_irq_ack clears it; with i_irq_en=0 no IRQ.

Source files
------------

// File: rtl/gametank_blitter.sv
// Rectangle copy / colour-fill engine: GRAM -> 128x128 VRAM, one pixel per clock.
// CPU programs offsets 0-7; a one-stage pipeline retires each GRAM read as a VRAM write.
module gametank_blitter #(
  parameter int FB_BITS = 7
) (
  input  logic                   i_clk_cpu,
  input  logic                   i_reset,
  input  logic                   i_ce,
  input  logic                   i_rnw,
  input  logic [2:0]             i_addr,
  input  logic [7:0]             i_data,
  input  logic                   i_dma_enable,
  input  logic                   i_colorfill,
  input  logic                   i_opaque,
  input  logic                   i_irq_en,
  input  logic [1:0]             i_gram_bank,
  input  logic                   i_irq_ack,
  output logic [2*FB_BITS+1:0]   o_gram_addr,
  output logic                   o_gram_re,
  input  logic [7:0]             i_gram_data,
  output logic [2*FB_BITS-1:0]   o_vram_addr,
  output logic                   o_vram_we,
  output logic [7:0]             o_vram_data,
  output logic                   o_busy,
  output logic                   o_irq
);

  localparam int F = FB_BITS;

  // state | meaning
  // IDLE  | waiting for START
  // RUN   | one GRAM read per cycle, previous pixel written
  // DRAIN | final pipelined VRAM write
  // DONE  | one cycle, IRQ raised on entry
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [F-1:0] reg_vx, reg_vy, reg_gx, reg_gy, reg_w, reg_h;
  logic         reg_flipx, reg_flipy;
  logic [7:0]   reg_color;

  logic [F-1:0] wvx, wvy, wgx, wgy, ww, wh;
  logic         wflipx, wflipy;
  logic [7:0]   wcolor;

  logic [F-1:0]   col, row;
  logic           valid;
  logic [2*F-1:0] dst_q;

  logic reg_wr, start_wr, start, irq_clr, last_px;
  logic [F-1:0] src_x, src_y, dst_x, dst_y;

  assign reg_wr   = i_ce & ~i_rnw;
  assign start_wr = reg_wr && (i_addr == 3'd6);
  assign start    = start_wr && i_data[0] && i_dma_enable && (state == IDLE);
  assign irq_clr  = i_irq_ack | (start_wr & ~i_data[0]);
  assign last_px  = (col == ww - 1'b1) && (row == wh - 1'b1);

  // All coordinate sums are F bits wide so they wrap inside their own field.
  always_comb begin
    src_x = wgx + (wflipx ? (ww - 1'b1 - col) : col);
    src_y = wgy + (wflipy ? (wh - 1'b1 - row) : row);
    dst_x = wvx + col;
    dst_y = wvy + row;
  end

  always_ff @(posedge i_clk_cpu) begin
    if (i_reset) begin
      state     <= IDLE;
      reg_vx    <= '0; reg_vy <= '0; reg_gx <= '0; reg_gy <= '0;
      reg_w     <= '0; reg_h  <= '0;
      reg_flipx <= 1'b0; reg_flipy <= 1'b0;
      reg_color <= '0;
      wvx <= '0; wvy <= '0; wgx <= '0; wgy <= '0; ww <= '0; wh <= '0;
      wflipx <= 1'b0; wflipy <= 1'b0; wcolor <= '0;
      col <= '0; row <= '0;
      valid <= 1'b0; dst_q <= '0;
      o_irq <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (i_addr)
          3'd0: reg_vx <= i_data[F-1:0];
          3'd1: reg_vy <= i_data[F-1:0];
          3'd2: reg_gx <= i_data[F-1:0];
          3'd3: reg_gy <= i_data[F-1:0];
          3'd4: begin reg_w <= i_data[F-1:0]; reg_flipx <= i_data[7]; end
          3'd5: begin reg_h <= i_data[F-1:0]; reg_flipy <= i_data[7]; end
          3'd7: reg_color <= i_data;
          default: ;
        endcase
      end

      // Clear first so a set below in the same cycle takes priority.
      if (irq_clr) o_irq <= 1'b0;
      valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            wvx <= reg_vx; wvy <= reg_vy; wgx <= reg_gx; wgy <= reg_gy;
            ww <= reg_w; wh <= reg_h;
            wflipx <= reg_flipx; wflipy <= reg_flipy; wcolor <= reg_color;
            col <= '0; row <= '0;
            if (reg_w == '0 || reg_h == '0) begin
              state <= DONE;
              if (i_irq_en) o_irq <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          valid <= 1'b1;
          dst_q <= {dst_y, dst_x};
          if (last_px) begin
            state <= DRAIN;
          end else if (col == ww - 1'b1) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
          if (i_irq_en) o_irq <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (state == RUN) || (state == DRAIN);
  assign o_gram_re   = (state == RUN) & ~i_colorfill;
  assign o_gram_addr = (state == RUN) ? {i_gram_bank, src_y, src_x} : '0;
  assign o_vram_addr = dst_q;
  assign o_vram_data = i_colorfill ? wcolor : i_gram_data;
  assign o_vram_we   = valid & (i_colorfill | i_opaque | (i_gram_data != 8'h00));

endmodule

// File: tb/tb_gametank_blitter.sv
// Self-checking bench for gametank_blitter: directed and randomized blits
// compared against a rectangle-level reference model of the expected VRAM writes.
module tb_gametank_blitter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ce = 1'b0, i_rnw = 1'b1;
  logic [2:0]  i_addr = '0;
  logic [7:0]  i_data = '0;
  logic        i_dma_enable = 1'b1, i_colorfill = 1'b0, i_opaque = 1'b1, i_irq_en = 1'b1;
  logic [1:0]  i_gram_bank = '0;
  logic        i_irq_ack = 1'b0;
  logic [15:0] o_gram_addr;
  logic        o_gram_re;
  logic [7:0]  gram_q = 8'h00;
  logic [13:0] o_vram_addr;
  logic        o_vram_we;
  logic [7:0]  o_vram_data;
  logic        o_busy, o_irq;

  gametank_blitter dut (
    .i_clk_cpu(clk), .i_reset(i_reset), .i_ce(i_ce), .i_rnw(i_rnw), .i_addr(i_addr),
    .i_data(i_data), .i_dma_enable(i_dma_enable), .i_colorfill(i_colorfill),
    .i_opaque(i_opaque), .i_irq_en(i_irq_en), .i_gram_bank(i_gram_bank),
    .i_irq_ack(i_irq_ack), .o_gram_addr(o_gram_addr), .o_gram_re(o_gram_re),
    .i_gram_data(gram_q), .o_vram_addr(o_vram_addr), .o_vram_we(o_vram_we),
    .o_vram_data(o_vram_data), .o_busy(o_busy), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  logic [7:0]  gram [0:65535];
  logic [21:0] wq[$];
  logic [21:0] exq[$];
  int n_re = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Synchronous GRAM: one-cycle read latency, noise when not reading.
  always @(posedge clk) begin
    if (o_gram_re) gram_q <= gram[o_gram_addr];
    else           gram_q <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (o_vram_we) wq.push_back({o_vram_addr, o_vram_data});
    if (o_gram_re) n_re++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    i_ce = 1'b1; i_rnw = 1'b0; i_addr = 3'(a); i_data = 8'(d);
    @(negedge clk);
    i_ce = 1'b0; i_rnw = 1'b1;
  endtask

  // Expected write list straight from the rectangle definition.
  task automatic model(input int vx, vy, gx, gy, w, h, input bit fx, fy, fill, opq,
                       input int color, bank);
    exq.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int sx, sy, dx, dy, d;
        sx = (gx + (fx ? (w - 1 - c) : c)) % 128;
        sy = (gy + (fy ? (h - 1 - r) : r)) % 128;
        dx = (vx + c) % 128;
        dy = (vy + r) % 128;
        d  = fill ? color : int'(gram[bank * 16384 + sy * 128 + sx]);
        if (fill || opq || d != 0) exq.push_back({14'(dy * 128 + dx), 8'(d)});
      end
  endtask

  // mode: 0 plain, 1 START+VX writes while busy, 2 hold i_irq_ack while busy.
  // ackm: 0 clear via i_irq_ack, 1 clear via START data 0, 2 leave pending.
  task automatic run_blit(input string tag, input int vx, vy, gx, gy, wreg, hreg, color,
                          input bit fill, opq, irqen, input int bank, mode, ackm);
    int w, h, cnt, exp_busy;
    w = wreg & 127; h = hreg & 127;
    i_colorfill = fill; i_opaque = opq; i_irq_en = irqen; i_gram_bank = 2'(bank);
    wr(0, vx); wr(1, vy); wr(2, gx); wr(3, gy); wr(4, wreg); wr(5, hreg); wr(7, color);
    model(vx, vy, gx, gy, w, h, wreg[7], hreg[7], fill, opq, color, bank);
    wq.delete(); n_re = 0;
    wr(6, 1);
    cnt = 0;
    while (o_busy && cnt < 2000) begin
      cnt++;
      i_ce = 1'b0; i_rnw = 1'b1;
      if (mode == 1 && cnt == 3) begin i_ce = 1'b1; i_rnw = 1'b0; i_addr = 3'd6; i_data = 8'd1; end
      if (mode == 1 && cnt == 5) begin i_ce = 1'b1; i_rnw = 1'b0; i_addr = 3'd0; i_data = 8'd55; end
      if (mode == 2) i_irq_ack = 1'b1;
      @(negedge clk);
    end
    i_ce = 1'b0; i_rnw = 1'b1; i_irq_ack = 1'b0;
    exp_busy = (w == 0 || h == 0) ? 0 : w * h + 1;
    check({tag, " busy_cycles"}, cnt, exp_busy);
    check({tag, " irq_at_done"}, o_irq, irqen);
    check({tag, " write_count"}, wq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < wq.size(); i++)
      check($sformatf("%s write%0d", tag, i), wq[i], exq[i]);
    check({tag, " gram_reads"}, n_re, fill ? 0 : w * h);
    if (ackm == 0) begin
      i_irq_ack = 1'b1; @(negedge clk); i_irq_ack = 1'b0;
      check({tag, " irq_ack"}, o_irq, 1'b0);
    end else if (ackm == 1) begin
      wr(6, 0);
      check({tag, " irq_start0"}, o_irq, 1'b0);
    end
  endtask

  initial begin
    for (int n = 0; n < 65536; n++) gram[n] = 8'(n + 1);
    repeat (3) @(negedge clk);
    check("reset busy", o_busy, 1'b0);
    check("reset irq", o_irq, 1'b0);
    check("reset vram_we", o_vram_we, 1'b0);
    check("reset gram_re", o_gram_re, 1'b0);
    check("reset vram_addr", o_vram_addr, 14'h0);
    check("reset gram_addr", o_gram_addr, 16'h0);
    i_reset = 1'b0;
    @(negedge clk);

    // Plain copy
    run_blit("copy", 10, 20, 0, 0, 4, 2, 0, 0, 1, 1, 0, 0, 0);
    if (wq.size() == 8) begin
      check("copy first", wq[0], {14'h0A0A, 8'd1});
      check("copy row1", wq[4], {14'h0A8A, 8'd129});
      check("copy last", wq[7], {14'h0A8D, 8'd132});
    end else check("copy size", wq.size(), 8);

    // Transparency with horizontal flip
    gram[30 * 128 + 20] = 8'd0; gram[30 * 128 + 21] = 8'd5;
    gram[30 * 128 + 22] = 8'd6; gram[30 * 128 + 23] = 8'd7;
    run_blit("transp", 0, 0, 20, 30, 8'h84, 1, 0, 0, 0, 1, 0, 0, 0);
    check("transp n", wq.size(), 3);
    if (wq.size() > 0) check("transp first", wq[0], {14'h0000, 8'd7});
    run_blit("opaque", 0, 0, 20, 30, 8'h84, 1, 0, 0, 1, 1, 0, 0, 0);
    check("opaque n", wq.size(), 4);

    // Wrapping colour fill
    run_blit("wrapfill", 126, 127, 5, 5, 4, 2, 8'h3C, 1, 0, 1, 0, 0, 0);
    if (wq.size() == 8) begin
      check("wrap w2", wq[2], {14'(127 * 128 + 0), 8'h3C});
      check("wrap w4", wq[4], {14'(0 * 128 + 126), 8'h3C});
    end else check("wrap size", wq.size(), 8);

    // Random GRAM contents with plenty of transparent pixels
    for (int n = 0; n < 65536; n++)
      gram[n] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);

    // START and VX writes during a blit must not disturb it
    run_blit("busywr", 3, 4, 7, 9, 8, 4, 0, 0, 0, 1, 1, 1, 0);

    // START with DMA disabled is ignored
    i_dma_enable = 1'b0; wq.delete();
    wr(6, 1);
    repeat (3) @(negedge clk);
    check("nodma busy", o_busy, 1'b0);
    check("nodma writes", wq.size(), 0);
    check("nodma irq", o_irq, 1'b0);
    i_dma_enable = 1'b1;

    // Reset at pixel 3 of a 16-pixel fill
    i_colorfill = 1'b1;
    wr(0, 5); wr(1, 6); wr(4, 16); wr(5, 1); wr(7, 8'h11);
    wq.delete();
    wr(6, 1);
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("rst vram_we", o_vram_we, 1'b0);
    check("rst busy", o_busy, 1'b0);
    check("rst irq", o_irq, 1'b0);
    check("rst writes", wq.size(), 3);
    i_reset = 1'b0;
    @(negedge clk);
    run_blit("afterrst", 9, 9, 1, 2, 5, 3, 0, 0, 1, 1, 0, 0, 0);

    // IRQ control
    run_blit("zero_w", 0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 0, 0, 0);
    run_blit("zero_h_s0", 0, 0, 0, 0, 4, 0, 0, 0, 1, 1, 0, 0, 1);
    run_blit("zero_noirq", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    run_blit("pend", 1, 1, 1, 1, 2, 2, 0, 0, 1, 1, 0, 0, 2);
    run_blit("setwins", 2, 2, 2, 2, 3, 2, 0, 0, 1, 1, 0, 2, 0);
    run_blit("noirq", 2, 2, 2, 2, 2, 2, 0, 0, 1, 0, 0, 0, 2);

    // Randomized blits
    for (int t = 0; t < 8; t++) begin
      int wv, hv;
      bit fl;
      wv = $urandom_range(1, 8) | ($urandom_range(0, 1) << 7);
      hv = $urandom_range(1, 5) | ($urandom_range(0, 1) << 7);
      fl = ($urandom_range(0, 2) == 0);
      run_blit($sformatf("rnd%0d", t), $urandom_range(0, 127), $urandom_range(0, 127),
               $urandom_range(0, 127), $urandom_range(0, 127), wv, hv,
               $urandom_range(0, 255), fl, $urandom_range(0, 1), 1,
               $urandom_range(0, 3), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
